// File: rtl/decode_imm_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_imm_stage (with helper imm_gen)
// Brief    : Decode-stage sequencer: classifies the opcode, generates the
//            immediate and holds up to two entries in a skid pipeline.
//            Optional macro DEC_ILLEGAL_EN enables unknown-opcode flagging.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef R_FORM
`define R_FORM  2'd0
`endif
`ifndef JU_FORM
`define JU_FORM 2'd1
`endif
`ifndef I_FORM
`define I_FORM  2'd2
`endif
`ifndef BS_FORM
`define BS_FORM 2'd3
`endif

// Immediates drop their always-zero low bits: branch gives imm[12:1],
// JAL gives imm[20:1], LUI/AUIPC give imm[31:12]; all sign-extended.
module imm_gen #(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    input  logic [1:0]      i_format,
    output logic [XLEN-1:0] o_imm
);
    always_comb begin
        o_imm = '0;
        case (i_format)
            `I_FORM:  o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            `BS_FORM: begin
                if (i_instr[6])
                    o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8]};
                else
                    o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            `JU_FORM: begin
                if (i_instr[6] && i_instr[3])
                    o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21]};
                else if (i_instr[6])
                    o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
                else
                    o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[31:12]};
            end
            default:  o_imm = '0;
        endcase
    end
endmodule

module decode_imm_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_pc,
    output logic [1:0]      o_format,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [1:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            ill;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{instr: 32'h0000_0013, pc: '0,
                                       fmt: `R_FORM, imm: '0, ill: 1'b0};

    state_t state_q, state_d;
    logic   valid_q, valid_d;
    logic   ready_q, ready_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;

    logic [1:0]      dec_format;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic            in_fire;
    logic            out_fire;
    entry_t          new_entry;

    always_comb begin
        dec_illegal = 1'b0;
        case (i_instr[6:0])
            7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111: dec_format = `JU_FORM;
            7'b0000011, 7'b0010011,
            7'b0011011:             dec_format = `I_FORM;
            7'b1100011, 7'b0100011: dec_format = `BS_FORM;
            7'b0110011, 7'b0111011: dec_format = `R_FORM;
            default: begin
                dec_format = `R_FORM;
`ifdef DEC_ILLEGAL_EN
                dec_illegal = 1'b1;
`endif
            end
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr  (i_instr),
        .i_format (dec_format),
        .o_imm    (dec_imm)
    );

    assign in_fire   = i_valid & ready_q;
    assign out_fire  = valid_q & i_ready;
    assign new_entry = '{instr: i_instr, pc: i_pc, fmt: dec_format,
                         imm: dec_imm, ill: dec_illegal};

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        head_d  = new_entry;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d  = new_entry;
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_d  = new_entry;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            head_q  <= RESET_ENTRY;
            skid_q  <= RESET_ENTRY;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_ready   = ready_q;
    assign o_instr   = head_q.instr;
    assign o_pc      = head_q.pc;
    assign o_format  = head_q.fmt;
    assign o_imm     = head_q.imm;
    // Without DEC_ILLEGAL_EN the captured flag is constant zero.
    assign o_illegal = head_q.ill;
endmodule

`default_nettype wire

// File: tb/tb_decode_imm_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_imm_stage
// Brief    : Directed self-checking bench for decode_imm_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_imm_stage;
    localparam logic [1:0] F_R  = 2'd0;
    localparam logic [1:0] F_JU = 2'd1;
    localparam logic [1:0] F_I  = 2'd2;
    localparam logic [1:0] F_BS = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        o_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        o_valid;
    logic        out_ready;
    logic [31:0] o_instr;
    logic [63:0] o_pc;
    logic [1:0]  o_format;
    logic [63:0] o_imm;
    logic        o_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    decode_imm_stage #(.XLEN(64), .PC_W(64)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_flush   (flush),
        .i_valid   (in_valid),
        .o_ready   (o_ready),
        .i_instr   (in_instr),
        .i_pc      (in_pc),
        .o_valid   (o_valid),
        .i_ready   (out_ready),
        .o_instr   (o_instr),
        .o_pc      (o_pc),
        .o_format  (o_format),
        .o_imm     (o_imm),
        .o_illegal (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p);
        in_valid = v;
        in_instr = ins;
        in_pc    = p;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        #12;
        check("rst_valid",  {63'd0, o_valid},  64'd0);
        check("rst_ready",  {63'd0, o_ready},  64'd1);
        check("rst_instr",  {32'd0, o_instr},  64'h13);
        check("rst_pc",     o_pc,              64'd0);
        check("rst_format", {62'd0, o_format}, {62'd0, F_R});
        check("rst_imm",    o_imm,             64'd0);
        check("rst_ill",    {63'd0, o_illegal}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single I-type through an idle stage
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF0_0093, 64'h100);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        check("addi_valid",  {63'd0, o_valid},  64'd1);
        check("addi_format", {62'd0, o_format}, {62'd0, F_I});
        check("addi_imm",    o_imm,             64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_pc",     o_pc,              64'h100);
        tick();
        check("addi_drain",  {63'd0, o_valid},  64'd0);

        // Backpressure: three back-to-back, only two fit
        out_ready = 1'b0;
        drive(1'b1, 32'hFE00_0EE3, 64'h200);
        tick();
        check("bp_one_ready", {63'd0, o_ready}, 64'd1);
        drive(1'b1, 32'h0080_006F, 64'h204);
        tick();
        check("bp_two_ready", {63'd0, o_ready}, 64'd0);
        check("bp_head_hold", {32'd0, o_instr}, 64'hFE00_0EE3);
        drive(1'b1, 32'h0050_0113, 64'h208);
        tick();
        check("bp_stall_ready", {63'd0, o_ready}, 64'd0);
        check("beq_instr",  {32'd0, o_instr},  64'hFE00_0EE3);
        check("beq_format", {62'd0, o_format}, {62'd0, F_BS});
        check("beq_imm",    o_imm,             64'hFFFF_FFFF_FFFF_FFFE);
        check("beq_pc",     o_pc,              64'h200);
        out_ready = 1'b1;
        tick();
        check("jal_instr",  {32'd0, o_instr},  64'h0080_006F);
        check("jal_format", {62'd0, o_format}, {62'd0, F_JU});
        check("jal_imm",    o_imm,             64'd4);
        check("jal_ready",  {63'd0, o_ready},  64'd1);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        check("addi5_instr", {32'd0, o_instr}, 64'h0050_0113);
        check("addi5_imm",   o_imm,            64'd5);
        check("addi5_pc",    o_pc,             64'h208);
        tick();
        check("bp_drain", {63'd0, o_valid}, 64'd0);

        // Flush while full, with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_2083, 64'h300);
        tick();
        drive(1'b1, 32'h0000_2103, 64'h304);
        tick();
        check("fl_full", {63'd0, o_ready}, 64'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_2183, 64'h308);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        check("fl_valid", {63'd0, o_valid}, 64'd0);
        check("fl_ready", {63'd0, o_ready}, 64'd1);
        tick();
        check("fl_stay_empty", {63'd0, o_valid}, 64'd0);
        drive(1'b1, 32'h0020_81B3, 64'h400);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        check("add_instr",  {32'd0, o_instr},  64'h0020_81B3);
        check("add_format", {62'd0, o_format}, {62'd0, F_R});
        check("add_imm",    o_imm,             64'd0);
        tick();
        check("add_drain",  {63'd0, o_valid},  64'd0);

        // Unknown opcode
        drive(1'b1, 32'h0000_007F, 64'h500);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        check("ill_valid",  {63'd0, o_valid},  64'd1);
        check("ill_format", {62'd0, o_format}, {62'd0, F_R});
        check("ill_imm",    o_imm,             64'd0);
`ifdef DEC_ILLEGAL_EN
        check("ill_flag",   {63'd0, o_illegal}, 64'd1);
`else
        check("ill_flag",   {63'd0, o_illegal}, 64'd0);
`endif
        tick();

        // Asynchronous reset while holding two entries
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF0_0093, 64'h600);
        tick();
        drive(1'b1, 32'h0080_006F, 64'h604);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, o_valid}, 64'd0);
        check("arst_ready", {63'd0, o_ready}, 64'd1);
        check("arst_instr", {32'd0, o_instr}, 64'h13);
        check("arst_imm",   o_imm,            64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_nothing", {63'd0, o_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
